// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory access stage:
// control-bus bit positions, handshake FSM states, default widths.
package mem_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int CTRL_W_DEF  = 22;
    localparam int TIMEOUT_DEF = 16;

    localparam int CB_IS_WB = 0;
    localparam int CB_IS_LD = 1;
    localparam int CB_IS_ST = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    // Load wins when both LD and ST are set.
    function automatic logic cb_is_store(input logic ld, input logic st);
        return st && !ld;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the memory stage and the data memory.
// The stage is the master; the memory model or bridge is the slave.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_access_stage_fsm.sv
// Req/ack handshake controller: tracks one outstanding access
// and produces commit/timeout strobes for the MEM/WB register.
module mem_handshake_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memop,
    input  logic is_store,
    input  logic ack,
    output logic req,
    output logic we,
    output logic busy,
    output logic commit,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        we      = 1'b0;
        commit  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                req = 1'b1;
                we  = is_store;
                // An ack in the last allowed cycle still counts as success.
                if (ack) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    commit  = 1'b1;
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == ACCESS);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: EX/MEM register, data-memory access via the handshake
// FSM, and the MEM/WB register with a sticky timeout error flag.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] input_EX_PC,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic [DATA_W-1:0] EX_op2,
    input  logic [DATA_W-1:0] input_EX_IR,
    input  logic [CTRL_W-1:0] input_EX_controlBus,
    output logic              stall_out,
    mem_access_stage_if.master dmem,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_PC,
    output logic [DATA_W-1:0] wb_IR,
    output logic [DATA_W-1:0] wb_aluResult,
    output logic [DATA_W-1:0] wb_ldResult,
    output logic [CTRL_W-1:0] wb_controlBus,
    output logic              mem_err
);

    logic              em_valid;
    logic [DATA_W-1:0] em_pc;
    logic [DATA_W-1:0] em_alu;
    logic [DATA_W-1:0] em_op2;
    logic [DATA_W-1:0] em_ir;
    logic [CTRL_W-1:0] em_cb;

    logic is_ld, is_st, memop;
    logic req, we, busy, commit, timeout;

    assign is_ld = em_cb[CB_IS_LD];
    assign is_st = em_cb[CB_IS_ST];
    assign memop = em_valid && (is_ld || is_st);

    // commit only fires in ACCESS on ack or on the final wait cycle.
    assign stall_out = memop && !commit;

    mem_handshake_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .memop    (memop),
        .is_store (cb_is_store(is_ld, is_st)),
        .ack      (dmem.dmem_ack),
        .req      (req),
        .we       (we),
        .busy     (busy),
        .commit   (commit),
        .timeout  (timeout)
    );

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = we;
    assign dmem.dmem_addr  = em_alu;
    assign dmem.dmem_wdata = em_op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_valid <= 1'b0;
            em_pc    <= '0;
            em_alu   <= '0;
            em_op2   <= '0;
            em_ir    <= '0;
            em_cb    <= '0;
        end else if (!stall_out) begin
            em_valid <= ex_valid;
            em_pc    <= input_EX_PC;
            em_alu   <= ALU_Result;
            em_op2   <= EX_op2;
            em_ir    <= input_EX_IR;
            em_cb    <= input_EX_controlBus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_PC         <= '0;
            wb_IR         <= '0;
            wb_aluResult  <= '0;
            wb_ldResult   <= '0;
            wb_controlBus <= '0;
        end else if (commit) begin
            wb_valid      <= 1'b1;
            wb_PC         <= em_pc;
            wb_IR         <= em_ir;
            wb_aluResult  <= em_alu;
            wb_ldResult   <= (is_ld && !timeout) ? dmem.dmem_rdata : '0;
            wb_controlBus <= em_cb;
        end else if (em_valid && !memop && !busy) begin
            wb_valid      <= 1'b1;
            wb_PC         <= em_pc;
            wb_IR         <= em_ir;
            wb_aluResult  <= em_alu;
            wb_ldResult   <= '0;
            wb_controlBus <= em_cb;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_err <= 1'b0;
        else if (timeout)
            mem_err <= 1'b1;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the ALU stage: holds the EX/MEM pipeline register, performs data-memory load/store over a req/ack handshake, and drives the MEM/WB pipeline register.
- Stalls upstream while a memory access is outstanding.
- Enforces a bounded wait with a timeout error flag.
- Non-memory instructions pass through with fixed 2-cycle latency.

Parameters:
- DATA_W, 32, width of PC, IR, ALU result, store data, load data
- CTRL_W, 22, width of control bus
- TIMEOUT, 16, max cycles in ACCESS without ack before forced completion (>=1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage presents a valid instruction
- input_EX_PC  input  DATA_W  PC from ALU stage
- ALU_Result  input  DATA_W  ALU result; memory address for loads/stores
- EX_op2  input  DATA_W  store data
- input_EX_IR  input  DATA_W  instruction word
- input_EX_controlBus  input  CTRL_W  control bus
- stall_out  output  1  upstream must hold EX outputs this cycle
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  DATA_W  memory address
- dmem_wdata  output  DATA_W  store data
- dmem_rdata  input  DATA_W  load data, valid with ack
- dmem_ack  input  1  one-cycle completion strobe
- wb_valid  output  1  MEM/WB register holds a valid instruction
- wb_PC, wb_IR, wb_aluResult, wb_ldResult  output  DATA_W  MEM/WB register fields
- wb_controlBus  output  CTRL_W  MEM/WB control bus
- mem_err  output  1  sticky: a timeout has occurred

Behaviour:
- Control bits: CB_IS_WB=0, CB_IS_LD=1, CB_IS_ST=2. If both LD and ST are set, the access is a load and ST is ignored.
- Reset (async, rst_n=0):
  - all registers and outputs go to 0, FSM=IDLE, wait counter=0, mem_err=0.
  - dmem_req drops immediately, including mid-access; the pending access is abandoned and produces no wb_valid.
- EX/MEM register:
  - loads all EX inputs plus ex_valid on every edge where stall_out=0.
  - holds while stall_out=1.
- memop = EX/MEM valid && (LD || ST).
- FSM states: IDLE, ACCESS.
  - IDLE: if memop, go to ACCESS and clear counter; else stay.
  - ACCESS:
    - dmem_req=1; dmem_we=ST&&!LD; dmem_addr and dmem_wdata come from the EX/MEM register (ALU result, op2).
    - on dmem_ack: commit, go to IDLE.
    - else if counter==TIMEOUT-1: forced commit with wb_ldResult=0, set mem_err, go to IDLE.
    - else counter++.
    - ack and timeout in the same cycle: ack wins, mem_err unchanged.
- dmem_req=0 and dmem_we=0 outside ACCESS; dmem_ack outside ACCESS is ignored.
- stall_out (combinational) = memop && !(state==ACCESS && (dmem_ack || counter==TIMEOUT-1)).
- MEM/WB register, every edge:
  - Non-memory valid instruction in IDLE: commit (wb_valid=1, fields copied, wb_ldResult=0).
  - Memory commit: fields copied; wb_ldResult=dmem_rdata for loads, 0 for stores.
  - Otherwise wb_valid=0 (bubble); other wb fields hold.
- Latency:
  - non-memory: EX/MEM captured at edge N, WB valid after edge N+1.
  - memory: req high after edge N+1; with ack in the following cycle, WB valid after edge N+2.
  - back-to-back non-memory throughput is 1/cycle.
- mem_err clears only on reset.

Decomposition:
- Package mem_stage_pkg: CB_* bit indices, FSM state enum (IDLE, ACCESS), default widths.
- One natural sub-module: mem_handshake_fsm (state, wait counter, req/we, commit and timeout strobes).
- The stage top holds the EX/MEM and MEM/WB registers.

Test Plan:
- Reset, then ALU op (ctrl=0x001, PC=0x10, ALU=0x55) with ex_valid=1 → wb_valid=1 two edges later, wb_aluResult=0x55, wb_ldResult=0, stall_out never high, dmem_req never high.
- Load ALU=0x100, memory acks 3 cycles after req with rdata=0xDEADBEEF → dmem_req=1/we=0/addr=0x100 for 3 cycles, stall_out high until the ack cycle, then wb_ldResult=0xDEADBEEF, wb_valid=1 for one cycle.
- Store ALU=0x200, op2=0x1234, immediate ack, followed by an ALU op → we=1, wdata=0x1234; ALU op enters EX/MEM on the ack edge and commits on the next edge; wb_valid pulses for each instruction in order.
- Load with no ack, TIMEOUT=16 → req high exactly 16 cycles, then wb_valid=1 with wb_ldResult=0, mem_err=1 and stays 1; a following access completes normally.
- Ack in the final timeout cycle (cycle 16) → normal commit with rdata, mem_err=0.
- rst_n low during ACCESS cycle 2 → dmem_req=0 immediately; after release FSM=IDLE, wb_valid=0; no commit of the abandoned load.
